// File: rtl/ds1302_access_scheduler.sv
// Sequences DS1302 controller accesses: periodic reads, writes first, CE-tracked completion with timeouts.
// Pulse starts the edge after the IDLE decision; requests arriving while busy stay pending until GUARD ends.
module ds1302_access_scheduler #(
    parameter int POLL_PERIOD   = 500000,
    parameter int PULSE_LEN     = 4,
    parameter int START_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT  = 2048,
    parameter int GAP_CYCLES    = 8
) (
    input  logic clk1,
    input  logic rstn,
    input  logic poll_en,
    input  logic wr_req,
    input  logic CE,
    output logic rd_btn,
    output logic wr_btn,
    output logic busy,
    output logic rd_done,
    output logic wr_done,
    output logic wr_pending,
    output logic timeout_err
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PULSE      = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_GUARD      = 3'd4;

    localparam int PW    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int M1    = (PULSE_LEN > START_TIMEOUT) ? PULSE_LEN : START_TIMEOUT;
    localparam int M2    = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int T_MAX = (M1 > M2) ? M1 : M2;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] BUSY_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          sel_wr_q, sel_wr_d;
    logic          wr_req_q, wr_req_d;
    logic          wr_pend_q, wr_pend_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_done_q, rd_done_d;
    logic          wr_done_q, wr_done_d;
    logic          err_q, err_d;

    logic wr_rise;
    logic poll_wrap;
    logic wr_issue;
    logic rd_issue;

    always_comb begin
        state_d    = state_q;
        sel_wr_d   = sel_wr_q;
        tmr_d      = tmr_q + TW'(1);
        rd_done_d  = 1'b0;
        wr_done_d  = 1'b0;
        err_d      = err_q;
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        wr_req_d   = wr_req;
        wr_rise    = wr_req & ~wr_req_q;
        poll_wrap  = 1'b0;
        poll_cnt_d = poll_cnt_q;

        // Poll counter free-runs regardless of FSM state so the read cadence stays fixed.
        if (!poll_en) begin
            poll_cnt_d = '0;
        end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d = '0;
            poll_wrap  = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (wr_pend_q) begin
                    state_d  = S_PULSE;
                    sel_wr_d = 1'b1;
                    wr_issue = 1'b1;
                end else if (rd_pend_q) begin
                    state_d  = S_PULSE;
                    sel_wr_d = 1'b0;
                    rd_issue = 1'b1;
                end
            end
            S_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = S_WAIT_START;
                    tmr_d   = '0;
                end
            end
            S_WAIT_START: begin
                if (CE) begin
                    state_d = S_WAIT_DONE;
                    tmr_d   = '0;
                end else if (tmr_q == START_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_GUARD;
                    tmr_d   = '0;
                end
            end
            S_WAIT_DONE: begin
                if (!CE) begin
                    rd_done_d = ~sel_wr_q;
                    wr_done_d = sel_wr_q;
                    state_d   = S_GUARD;
                    tmr_d     = '0;
                end else if (tmr_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_GUARD;
                    tmr_d   = '0;
                end
            end
            S_GUARD: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        // A new request in the issuing cycle wins over the clear, so it is never lost.
        wr_pend_d = wr_rise | (wr_pend_q & ~wr_issue);
        rd_pend_d = poll_wrap | (rd_pend_q & ~rd_issue);
    end

    always_ff @(posedge clk1) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            poll_cnt_q <= '0;
            sel_wr_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            poll_cnt_q <= poll_cnt_d;
            sel_wr_q   <= sel_wr_d;
            wr_req_q   <= wr_req_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
        end
    end

    assign rd_btn      = (state_q == S_PULSE) && !sel_wr_q;
    assign wr_btn      = (state_q == S_PULSE) && sel_wr_q;
    assign busy        = (state_q != S_IDLE);
    assign rd_done     = rd_done_q;
    assign wr_done     = wr_done_q;
    assign wr_pending  = wr_pend_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_ds1302_access_scheduler.sv
// Scoreboard bench: a transaction-level model predicts output events per cycle, a monitor matches them.
module tb_ds1302_access_scheduler;

    localparam int P = 20, PL = 2, ST = 8, BT = 50, GAP = 3, CE_HIGH = 10;
    localparam int CE_NORMAL = 0, CE_DEAD = 1, CE_STUCK1 = 2;
    localparam int K_RD_RISE = 0, K_RD_FALL = 1, K_WR_RISE = 2, K_WR_FALL = 3;
    localparam int K_RD_DONE = 4, K_WR_DONE = 5, K_ERR_RISE = 6, K_ERR_FALL = 7;
    localparam int K_BUSY_RISE = 8, K_BUSY_FALL = 9, K_WP_RISE = 10, K_WP_FALL = 11, K_BOTH = 12;

    logic clk1 = 1'b0;
    logic rstn = 1'b0;
    logic poll_en = 1'b0;
    logic wr_req = 1'b0;
    logic ce = 1'b0;
    logic rd_btn, wr_btn, busy, rd_done, wr_done, wr_pending, timeout_err;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  rst_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ce_mode = CE_NORMAL;

    ds1302_access_scheduler #(
        .POLL_PERIOD(P), .PULSE_LEN(PL), .START_TIMEOUT(ST),
        .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)
    ) dut (
        .clk1(clk1), .rstn(rstn), .poll_en(poll_en), .wr_req(wr_req), .CE(ce),
        .rd_btn(rd_btn), .wr_btn(wr_btn), .busy(busy), .rd_done(rd_done),
        .wr_done(wr_done), .wr_pending(wr_pending), .timeout_err(timeout_err)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    // Behavioural DS1302 controller: CE rises the cycle after the request pulse falls.
    logic [1:0] btn_hist = 2'b00;
    int ce_left = 0;
    initial forever begin
        @(negedge clk1);
        btn_hist = rstn ? {btn_hist[0], rd_btn | wr_btn} : 2'b00;
    end
    initial forever begin
        @(posedge clk1);
        #2;
        if (!rstn) ce_left = 0;
        else if (btn_hist == 2'b10 && ce_mode != CE_DEAD)
            ce_left = (ce_mode == CE_STUCK1) ? 1000000 : CE_HIGH;
        ce = (ce_left > 0);
        if (ce_left > 0 && ce_mode != CE_STUCK1) ce_left--;
    end

    task automatic push_ev(input int c, input int k);
        ev_t ev;
        int i;
        ev.cyc = c;
        ev.kind = k;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, ev);
    endtask

    // Reference model: requests, priorities and transaction durations as plain arithmetic.
    int m_poll = 0, m_idle = 0;
    bit m_wr_prev = 0, m_wr_pend = 0, m_rd_pend = 0, m_err = 0;

    task automatic schedule(input bit is_wr, input int d);
        int t_end;
        push_ev(d, is_wr ? K_WR_RISE : K_RD_RISE);
        push_ev(d, K_BUSY_RISE);
        push_ev(d + PL, is_wr ? K_WR_FALL : K_RD_FALL);
        if (ce_mode == CE_NORMAL) begin
            t_end = d + PL + 2 + CE_HIGH;
            push_ev(t_end, is_wr ? K_WR_DONE : K_RD_DONE);
        end else if (ce_mode == CE_DEAD) begin
            t_end = d + PL + ST;
        end else begin
            t_end = d + PL + 2 + BT;
        end
        if (ce_mode != CE_NORMAL && !m_err) begin
            push_ev(t_end, K_ERR_RISE);
            m_err = 1;
        end
        m_idle = t_end + GAP;
        push_ev(m_idle, K_BUSY_FALL);
    endtask

    always @(negedge clk1) begin : model
        int e;
        bit wr_set, rd_set, issue_wr, issue_rd, old_wp;
        e = cyc + 1;
        if (!rstn) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].cyc >= e) exp_q.delete(i);
            rst_q.push_back(e);
            m_poll = 0; m_wr_prev = 0; m_wr_pend = 0; m_rd_pend = 0; m_err = 0;
            m_idle = e;
        end else begin
            wr_set = wr_req && !m_wr_prev;
            m_wr_prev = wr_req;
            rd_set = 0;
            if (!poll_en) m_poll = 0;
            else if (m_poll == P - 1) begin m_poll = 0; rd_set = 1; end
            else m_poll++;
            issue_wr = 0;
            issue_rd = 0;
            if (cyc >= m_idle) begin
                if (m_wr_pend) issue_wr = 1;
                else if (m_rd_pend) issue_rd = 1;
            end
            old_wp = m_wr_pend;
            m_wr_pend = wr_set || (m_wr_pend && !issue_wr);
            m_rd_pend = rd_set || (m_rd_pend && !issue_rd);
            if (m_wr_pend != old_wp) push_ev(e, m_wr_pend ? K_WP_RISE : K_WP_FALL);
            if (issue_wr || issue_rd) schedule(issue_wr, e);
        end
    end

    bit p_rd = 0, p_wr = 0, p_err = 0, p_busy = 0, p_wp = 0;
    always @(negedge clk1) begin : monitor
        int n, obs, expm;
        ev_t ev;
        n = cyc;
        if (n >= 2) begin
            obs = 0;
            if (rd_btn && !p_rd) obs |= (1 << K_RD_RISE);
            if (!rd_btn && p_rd) obs |= (1 << K_RD_FALL);
            if (wr_btn && !p_wr) obs |= (1 << K_WR_RISE);
            if (!wr_btn && p_wr) obs |= (1 << K_WR_FALL);
            if (rd_done) obs |= (1 << K_RD_DONE);
            if (wr_done) obs |= (1 << K_WR_DONE);
            if (timeout_err && !p_err) obs |= (1 << K_ERR_RISE);
            if (!timeout_err && p_err) obs |= (1 << K_ERR_FALL);
            if (busy && !p_busy) obs |= (1 << K_BUSY_RISE);
            if (!busy && p_busy) obs |= (1 << K_BUSY_FALL);
            if (wr_pending && !p_wp) obs |= (1 << K_WP_RISE);
            if (!wr_pending && p_wp) obs |= (1 << K_WP_FALL);
            if (rd_btn && wr_btn) obs |= (1 << K_BOTH);
            while (exp_q.size() > 0 && exp_q[0].cyc < n) begin
                ev = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event cyc=%0d got=absent want=kind%0d@%0d", n, ev.kind, ev.cyc);
            end
            while (rst_q.size() > 0 && rst_q[0] < n) void'(rst_q.pop_front());
            if (rst_q.size() > 0 && rst_q[0] == n) begin
                void'(rst_q.pop_front());
                while (exp_q.size() > 0 && exp_q[0].cyc == n) void'(exp_q.pop_front());
                n_cmp++;
                if ({rd_btn, wr_btn, busy, rd_done, wr_done, wr_pending, timeout_err} !== 7'b0) begin
                    n_bad++;
                    $display("FAIL reset_clear cyc=%0d got=%b want=0000000", n,
                             {rd_btn, wr_btn, busy, rd_done, wr_done, wr_pending, timeout_err});
                end
            end else begin
                expm = 0;
                while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
                    ev = exp_q.pop_front();
                    expm |= (1 << ev.kind);
                end
                if (expm != 0 || obs != 0) begin
                    n_cmp++;
                    if (obs != expm) begin
                        n_bad++;
                        $display("FAIL events cyc=%0d got=%h want=%h", n, obs, expm);
                    end
                end
            end
        end
        p_rd = rd_btn; p_wr = wr_btn; p_err = timeout_err; p_busy = busy; p_wp = wr_pending;
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset(input int mode);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        ce_mode = mode;
    endtask

    initial begin
        tick();
        tick();
        rstn = 1'b1;

        // Periodic reads only.
        do_reset(CE_NORMAL);
        poll_en = 1'b1;
        run(100);

        // Write rise lands on the poll wrap edge: write goes first.
        do_reset(CE_NORMAL);
        poll_en = 1'b1;
        run(19);
        wr_req = 1'b1;
        run(3);
        wr_req = 1'b0;
        run(60);

        // Three rises during an active write coalesce to one extra write.
        do_reset(CE_NORMAL);
        poll_en = 1'b0;
        wr_req = 1'b1; tick(); wr_req = 1'b0;
        run(4);
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; tick(); wr_req = 1'b0; tick();
        end
        run(50);

        // CE never rises: start timeout, then polling continues.
        do_reset(CE_DEAD);
        poll_en = 1'b1;
        run(50);

        // CE never falls: busy timeout, reset just as GUARD ends.
        do_reset(CE_STUCK1);
        poll_en = 1'b1;
        run(78);

        // Reset while rd_btn is high.
        do_reset(CE_NORMAL);
        poll_en = 1'b1;
        run(22);
        do_reset(CE_NORMAL);
        run(45);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 4) poll_en = ~poll_en;
            if ($urandom_range(0, 99) < 4) wr_req = ~wr_req;
            if ($urandom_range(0, 999) < 2) do_reset(CE_NORMAL);
            else tick();
        end

        poll_en = 1'b0;
        wr_req = 1'b0;
        do_reset(CE_NORMAL);
        run(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
